// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with input synchroniser, mid-bit sampling, glitch rejection and framing-error detection
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int N = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] MAX_CNT = 16'(N - 1);
    localparam logic [15:0] HALF_CNT = 16'(N / 2 - 1);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] STOP = 3'd3;
    localparam logic [2:0] ERR = 3'd4;
    logic                 r_meta;
    logic                 r_sync;
    logic                 r_prev;
    logic [2:0]           r_state;
    logic [15:0]          r_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           w_next;
    logic                 w_fall;
    logic                 w_tick;
    logic                 w_half;
    logic                 w_stop_tick;
    assign w_fall = r_prev & ~r_sync;
    assign w_tick = r_cnt == MAX_CNT;
    assign w_half = r_cnt == HALF_CNT;
    assign w_stop_tick = r_state == STOP && w_tick;
    assign rx_busy = r_state != IDLE;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_fall ? START : IDLE;
            START:   w_next = w_half ? (r_sync ? IDLE : DATA) : START;
            DATA:    w_next = (w_tick && r_bit_cnt == LAST_BIT) ? STOP : DATA;
            STOP:    w_next = w_tick ? (r_sync ? IDLE : ERR) : STOP;
            ERR:     w_next = r_sync ? IDLE : ERR;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_meta    <= 1'b1;
            r_sync    <= 1'b1;
            r_prev    <= 1'b1;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_meta    <= rx;
            r_sync    <= r_meta;
            r_prev    <= r_sync;
            r_state   <= w_next;
            r_cnt     <= (r_state == IDLE || w_next != r_state || w_tick) ? '0 : r_cnt + 16'd1;
            rx_done   <= w_stop_tick && r_sync;
            frame_err <= w_stop_tick && !r_sync;
            if (r_state == DATA && w_tick) begin
                r_shift   <= {r_sync, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 4'd1;
            end
            if (w_stop_tick && r_sync)
                rx_data <= 8'(r_shift);
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level event model
module tb_uart_rx;
    localparam int N = 50_000_000 / 115_200;
    localparam int LAT = (19 * N) / 2;
    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;
    uart_rx dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .rx(rx),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .frame_err(frame_err),
        .rx_busy(rx_busy)
    );
    always #10 sys_clk = ~sys_clk;
    typedef struct {
        bit         err;
        logic [7:0] data;
        int         start;
    } ev_t;
    ev_t        exp_q[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         last_start = 0;
    int         last_done = 0;
    logic [7:0] exp_data = 8'h00;
    logic       rst_seen = 1'b0;
    always @(posedge sys_clk) begin
        cyc++;
        rst_seen = sys_rst;
    end
    task automatic check(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask
    task automatic send_frame(input logic [7:0] b, input int p, input bit stop);
        last_start = cyc;
        exp_q.push_back('{!stop, b, cyc});
        rx = 1'b0;
        tick(p);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(p);
        end
        rx = stop;
        tick(p);
    endtask
    always @(negedge sys_clk) begin
        if (rst_seen) begin
            exp_data = 8'h00;
            exp_q.delete();
        end
        if (rx_done || frame_err) begin
            if (rx_done) begin
                done_cnt++;
                last_done = cyc;
            end
            if (frame_err)
                ferr_cnt++;
            check(!(rx_done && frame_err), "done_and_err", {rx_done, frame_err}, 0);
            check(exp_q.size() != 0, "unexpected_event", {rx_done, frame_err}, 0);
            if (exp_q.size() != 0) begin
                ev_t e;
                e = exp_q.pop_front();
                check(frame_err == e.err, "event_kind", frame_err, e.err);
                check(cyc - e.start >= LAT + 3 && cyc - e.start <= LAT + 5, "latency", cyc - e.start, LAT + 3);
                if (!e.err)
                    exp_data = e.data;
            end
        end else if (exp_q.size() != 0 && cyc - exp_q[0].start > LAT + 5) begin
            n_chk++;
            n_fail++;
            $display("FAIL missing_event: got none, expected kind %0d data %0d", exp_q[0].err, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        check(rx_data == exp_data, "rx_data", rx_data, exp_data);
    end
    initial begin
        logic [7:0] b;
        int         d0;
        int         p;
        int         g;
        bit         bad;
        tick(3);
        check(rx_data == 8'h00, "reset_data", rx_data, 0);
        check(rx_busy == 1'b0, "reset_busy", rx_busy, 0);
        check(rx_done == 1'b0 && frame_err == 1'b0, "reset_pulses", {rx_done, frame_err}, 0);
        sys_rst = 1'b0;
        tick(20);
        send_frame(8'h55, N, 1'b1);
        check(done_cnt == 1, "t1_done_count", done_cnt, 1);
        check(last_done - last_start >= 4126 && last_done - last_start <= 4128, "t1_latency", last_done - last_start, 4126);
        check(rx_data == 8'h55, "t1_data", rx_data, 8'h55);
        check(ferr_cnt == 0, "t1_ferr", ferr_cnt, 0);
        check(rx_busy == 1'b0, "t1_busy", rx_busy, 0);
        send_frame(8'hA3, N, 1'b1);
        check(rx_data == 8'hA3, "t2_data_a", rx_data, 8'hA3);
        d0 = last_done;
        send_frame(8'h0F, N, 1'b1);
        check(last_done - d0 >= 4338 && last_done - d0 <= 4342, "t2_spacing", last_done - d0, 4340);
        check(rx_data == 8'h0F, "t2_data_b", rx_data, 8'h0F);
        check(done_cnt == 3, "t2_done_count", done_cnt, 3);
        tick(N);
        rx = 1'b0;
        tick(100);
        rx = 1'b1;
        for (int i = 0; i < 220 && rx_busy; i++)
            tick(1);
        check(rx_busy == 1'b0, "t3_glitch_busy", rx_busy, 0);
        tick(1000);
        send_frame(8'h3C, N, 1'b1);
        check(rx_data == 8'h3C, "t3_data", rx_data, 8'h3C);
        check(done_cnt == 4 && ferr_cnt == 0, "t3_counts", done_cnt * 10 + ferr_cnt, 40);
        send_frame(8'hFF, N, 1'b0);
        tick(3 * N);
        rx = 1'b1;
        tick(N);
        check(ferr_cnt == 1, "t4_ferr_count", ferr_cnt, 1);
        check(done_cnt == 4, "t4_no_done", done_cnt, 4);
        check(rx_data == 8'h3C, "t4_data_held", rx_data, 8'h3C);
        send_frame(8'h81, N, 1'b1);
        check(rx_data == 8'h81, "t4_next_data", rx_data, 8'h81);
        tick(N);
        b = 8'h5A;
        rx = 1'b0;
        tick(N);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            tick(N);
        end
        rx = b[3];
        tick(N / 2);
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        rx = 1'b1;
        check(rx_data == 8'h00, "t5_reset_data", rx_data, 0);
        check(rx_busy == 1'b0, "t5_reset_busy", rx_busy, 0);
        check(rx_done == 1'b0 && frame_err == 1'b0, "t5_reset_pulses", {rx_done, frame_err}, 0);
        tick(2 * N);
        check(done_cnt == 5 && ferr_cnt == 1, "t5_no_pulse", done_cnt * 10 + ferr_cnt, 51);
        send_frame(8'hC7, N, 1'b1);
        check(rx_data == 8'hC7, "t5_data", rx_data, 8'hC7);
        tick(N);
        send_frame(8'h96, 447, 1'b1);
        check(rx_data == 8'h96, "t6_slow_data", rx_data, 8'h96);
        tick(N);
        send_frame(8'h96, 421, 1'b1);
        check(rx_data == 8'h96, "t6_fast_data", rx_data, 8'h96);
        check(ferr_cnt == 1 && done_cnt == 8, "t6_counts", done_cnt * 10 + ferr_cnt, 81);
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            p = $urandom_range(447, 421);
            bad = $urandom_range(4, 0) == 0;
            send_frame(b, p, !bad);
            if (bad) begin
                tick($urandom_range(3 * N, 1));
                rx = 1'b1;
                tick(N);
            end else begin
                g = $urandom_range(300, 0);
                if (g != 0)
                    tick(g);
            end
        end
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++)
            tick(1);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
